// File: rtl/rr_arbiter_if.sv
// rtl/rr_arbiter_if.sv - request/grant bundle between requesters and the arbiter.
interface rr_arbiter_if #(
  parameter int N = 16
) ();
  localparam int IDX_W = $clog2(N);

  logic [N-1:0]     req;
  logic [N-1:0]     grant;
  logic             grant_valid;
  logic [IDX_W-1:0] grant_idx;
  logic             busy;

  modport master (
    output req,
    input  grant,
    input  grant_valid,
    input  grant_idx,
    input  busy
  );

  modport slave (
    input  req,
    output grant,
    output grant_valid,
    output grant_idx,
    output busy
  );
endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - registered N-way arbiter with fixed/round-robin priority, grant lock and hold limit.
module rr_arbiter #(
  parameter int N        = 16,
  parameter int MODE     = 1,
  parameter int MAX_HOLD = 0
) (
  input  logic        clk,
  input  logic        reset,
  rr_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(N);
  localparam int HC_W  = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  typedef enum logic {IDLE, GRANT} state_e;

  state_e           state_q;
  logic [N-1:0]     grant_q;
  logic [IDX_W-1:0] grant_idx_q;
  logic [IDX_W-1:0] ptr_q;
  logic [HC_W-1:0]  hold_cnt_q;
  logic             busy_q;

  logic [N-1:0]     cand;
  logic             found;
  logic [IDX_W-1:0] win;
  logic [N-1:0]     win_oh;
  logic             holder_req;
  logic             preempt;
  logic             rearb;

  // The holder is always excluded from the search: a search only runs on
  // release or preemption, and grant_q is all-zero when idle.
  always_comb begin
    cand  = bus.req & ~grant_q;
    found = 1'b0;
    win   = '0;
    for (int off = 0; off < N; off++) begin
      int pos;
      pos = (int'(ptr_q) + N - off) % N;
      if (!found && cand[pos]) begin
        found = 1'b1;
        win   = IDX_W'(pos);
      end
    end
    win_oh = N'(1) << win;
  end

  always_comb begin
    holder_req = bus.req[grant_idx_q];
    preempt    = (MAX_HOLD > 0) && (state_q == GRANT) && holder_req &&
                 (int'(hold_cnt_q) == MAX_HOLD - 1) && (|cand);
    rearb      = (state_q == IDLE) || !holder_req || preempt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      grant_idx_q <= '0;
      ptr_q       <= IDX_W'(N - 1);
      hold_cnt_q  <= '0;
      busy_q      <= 1'b0;
    end else if (rearb) begin
      if (found) begin
        state_q     <= GRANT;
        grant_q     <= win_oh;
        grant_idx_q <= win;
        hold_cnt_q  <= '0;
        busy_q      <= |(bus.req & ~win_oh);
        if (MODE != 0) begin
          ptr_q <= (win == '0) ? IDX_W'(N - 1) : win - 1'b1;
        end
      end else begin
        state_q     <= IDLE;
        grant_q     <= '0;
        grant_idx_q <= '0;
        hold_cnt_q  <= '0;
        busy_q      <= 1'b0;
      end
    end else begin
      if (int'(hold_cnt_q) < MAX_HOLD) begin
        hold_cnt_q <= hold_cnt_q + 1'b1;
      end
      busy_q <= |(bus.req & ~grant_q);
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = |grant_q;
  assign bus.grant_idx   = grant_idx_q;
  assign bus.busy        = busy_q;
endmodule

// File: tb/tb_rr_arbiter.sv
// tb/tb_rr_arbiter.sv - randomized and directed bench for rr_arbiter against a behavioural model.
module tb_rr_arbiter;
  localparam int N  = 4;
  localparam int NU = 3;

  logic         clk   = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] req_v = '0;

  always #5 clk = ~clk;

  rr_arbiter_if #(.N(N)) if0 ();
  rr_arbiter_if #(.N(N)) if1 ();
  rr_arbiter_if #(.N(N)) if2 ();

  assign if0.req = req_v;
  assign if1.req = req_v;
  assign if2.req = req_v;

  rr_arbiter #(.N(N), .MODE(0), .MAX_HOLD(0)) u0 (.clk(clk), .reset(reset), .bus(if0.slave));
  rr_arbiter #(.N(N), .MODE(1), .MAX_HOLD(0)) u1 (.clk(clk), .reset(reset), .bus(if1.slave));
  rr_arbiter #(.N(N), .MODE(1), .MAX_HOLD(3)) u2 (.clk(clk), .reset(reset), .bus(if2.slave));

  logic [N-1:0] g_obs [NU];
  logic         v_obs [NU];
  logic [1:0]   i_obs [NU];
  logic         b_obs [NU];

  assign g_obs[0] = if0.grant; assign v_obs[0] = if0.grant_valid;
  assign i_obs[0] = if0.grant_idx; assign b_obs[0] = if0.busy;
  assign g_obs[1] = if1.grant; assign v_obs[1] = if1.grant_valid;
  assign i_obs[1] = if1.grant_idx; assign b_obs[1] = if1.busy;
  assign g_obs[2] = if2.grant; assign v_obs[2] = if2.grant_valid;
  assign i_obs[2] = if2.grant_idx; assign b_obs[2] = if2.busy;

  int n_checks = 0;
  int n_errors = 0;

  int mode_c [NU] = '{0, 1, 1};
  int maxh_c [NU] = '{0, 0, 3};
  int holder [NU];
  int ptr_m  [NU];
  int cnt_m  [NU];
  int busy_m [NU];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Descend from p with wrap, skipping the current holder.
  function automatic int search(input int r, input int p, input int skip);
    for (int off = 0; off < N; off++) begin
      int i;
      i = (p - off + N) % N;
      if (i != skip && r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_step(input int k);
    int r, w, h;
    bit regrant;
    r = int'(req_v);
    if (reset) begin
      holder[k] = -1; ptr_m[k] = N - 1; cnt_m[k] = 0; busy_m[k] = 0;
      return;
    end
    h = holder[k];
    regrant = 0;
    w = -1;
    if (h < 0) begin
      w = search(r, ptr_m[k], -1);
      regrant = 1;
    end else if (!r[h]) begin
      w = search(r, ptr_m[k], h);
      regrant = 1;
    end else if (maxh_c[k] > 0 && cnt_m[k] == maxh_c[k] - 1 && (r & ~(1 << h)) != 0) begin
      w = search(r, ptr_m[k], h);
      regrant = 1;
    end else if (cnt_m[k] < maxh_c[k]) begin
      cnt_m[k]++;
    end
    if (regrant) begin
      holder[k] = w;
      cnt_m[k]  = 0;
      if (w >= 0 && mode_c[k] != 0) ptr_m[k] = (w == 0) ? N - 1 : w - 1;
    end
    busy_m[k] = (holder[k] >= 0 && (r & ~(1 << holder[k])) != 0) ? 1 : 0;
  endtask

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < NU; k++) model_step(k);
    @(negedge clk);
    for (int k = 0; k < NU; k++) begin
      int eg, ei;
      eg = (holder[k] >= 0) ? (1 << holder[k]) : 0;
      ei = (holder[k] >= 0) ? holder[k] : 0;
      check($sformatf("u%0d.grant", k), 32'(g_obs[k]), 32'(eg));
      check($sformatf("u%0d.grant_valid", k), 32'(v_obs[k]), 32'(holder[k] >= 0));
      check($sformatf("u%0d.grant_idx", k), 32'(i_obs[k]), 32'(ei));
      check($sformatf("u%0d.busy", k), 32'(b_obs[k]), 32'(busy_m[k]));
    end
  endtask

  int order [5] = '{3, 2, 1, 0, 3};

  initial begin
    for (int k = 0; k < NU; k++) begin
      holder[k] = -1; ptr_m[k] = N - 1; cnt_m[k] = 0; busy_m[k] = 0;
    end

    reset = 1'b1;
    tick(); tick();
    check("reset.grant", 32'(if0.grant), 32'd0);
    check("reset.valid", 32'(if0.grant_valid), 32'd0);
    check("reset.idx", 32'(if0.grant_idx), 32'd0);
    check("reset.busy", 32'(if0.busy), 32'd0);
    reset = 1'b0;

    req_v = 4'b0101;
    tick();
    check("fixed.first_grant", 32'(if0.grant), 32'b0100);
    check("fixed.first_idx", 32'(if0.grant_idx), 32'd2);
    check("fixed.first_busy", 32'(if0.busy), 32'd1);

    req_v = 4'b1101;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("fixed.locked", 32'(if0.grant), 32'b0100);
    end
    req_v = 4'b1001;
    tick();
    check("fixed.handover", 32'(if0.grant), 32'b1000);
    check("fixed.handover_idx", 32'(if0.grant_idx), 32'd3);

    reset = 1'b1; tick(); reset = 1'b0;
    req_v = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("rr.order", 32'(if1.grant_idx), 32'(order[c]));
      req_v = 4'b1111 & ~(4'b0001 << order[c]);
    end

    reset = 1'b1; tick(); reset = 1'b0;
    req_v = 4'b1001;
    for (int c = 0; c < 9; c++) begin
      tick();
      check("hold.preempt", 32'(if2.grant), (c >= 3 && c < 6) ? 32'b0001 : 32'b1000);
    end

    req_v = 4'b0010;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("hold.sole_grant", 32'(if2.grant), 32'b0010);
      check("hold.sole_busy", 32'(if2.busy), 32'd0);
    end

    req_v = 4'b0100;
    tick();
    check("rst.pre_grant", 32'(if0.grant), 32'b0100);
    reset = 1'b1;
    tick();
    check("rst.mid_grant", 32'(if0.grant), 32'd0);
    check("rst.mid_valid", 32'(if0.grant_valid), 32'd0);
    reset = 1'b0;
    req_v = 4'b1111;
    tick();
    check("rst.after_fixed", 32'(if0.grant), 32'b1000);
    check("rst.after_rr", 32'(if1.grant), 32'b1000);
    check("rst.after_hold", 32'(if2.grant), 32'b1000);

    for (int c = 0; c < 3000; c++) begin
      req_v = req_v ^ N'($urandom & $urandom);
      reset = ($urandom_range(0, 79) == 0);
      tick();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
